// File: rtl/madd_approx_pipe_eval.sv
// Two-stage pipelined multiply-add y = a*b + c with an exact and a column-truncated
// approximate result, per-sample error distance and saturating running error statistics.
module madd_approx_pipe_eval #(
    parameter int W     = 6,
    parameter int TRUNC = 3,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    input  logic [W-1:0]        c,
    input  logic                approx_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*W-1:0]      y_exact,
    output logic [2*W-1:0]      y_approx,
    output logic [2*W-1:0]      err_dist,
    input  logic                stat_clr,
    output logic [CNT_W-1:0]    n_samples,
    output logic [CNT_W-1:0]    n_err,
    output logic [CNT_W-1:0]    sum_err,
    output logic [2*W-1:0]      max_err
);

    localparam int PW = 2 * W;
    localparam int SW = ((PW > CNT_W) ? PW : CNT_W) + 1;
    localparam logic [CNT_W-1:0] CNT_ALL = {CNT_W{1'b1}};

    // Handshake: a stage advances only when en=1 (output empty or being
    // taken); in_ready mirrors en, so accepted samples are never dropped.
    logic en;

    logic            v1_q;
    logic [PW-1:0]   pp_hi_q, pp_hi_d;
    logic [PW-1:0]   pp_lo_q, pp_lo_d;
    logic [W-1:0]    c1_q;
    logic            ae1_q;

    logic            out_valid_q;
    logic [PW-1:0]   y_exact_q, y_exact_d;
    logic [PW-1:0]   y_approx_q, y_approx_d;
    logic [PW-1:0]   err_q, err_d;
    logic [W-1:0]    c_hi;

    logic [CNT_W-1:0] n_samples_q, n_samples_d;
    logic [CNT_W-1:0] n_err_q, n_err_d;
    logic [CNT_W-1:0] sum_err_q, sum_err_d;
    logic [PW-1:0]    max_err_q, max_err_d;
    logic [SW-1:0]    sum_wide;
    logic             out_hs;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;
    assign out_hs   = out_valid_q & out_ready;

    // Stage 1: weighted partial-product bits split into kept (i+j >= TRUNC) and dropped columns.
    always_comb begin
        pp_hi_d = '0;
        pp_lo_d = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (a[i] & b[j]) begin
                    if (i + j >= TRUNC) pp_hi_d = pp_hi_d + (PW'(1) << (i + j));
                    else                pp_lo_d = pp_lo_d + (PW'(1) << (i + j));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            pp_hi_q <= '0;
            pp_lo_q <= '0;
            c1_q    <= '0;
            ae1_q   <= 1'b0;
        end else if (en) begin
            v1_q    <= in_valid;
            pp_hi_q <= pp_hi_d;
            pp_lo_q <= pp_lo_d;
            c1_q    <= c;
            ae1_q   <= approx_en;
        end
    end

    // Stage 2: final sums; c loses its low TRUNC bits on the approximate path.
    always_comb begin
        c_hi = '0;
        for (int k = 0; k < W; k++) c_hi[k] = (k >= TRUNC) ? c1_q[k] : 1'b0;
        y_exact_d  = pp_hi_q + pp_lo_q + PW'(c1_q);
        y_approx_d = ae1_q ? (pp_hi_q + PW'(c_hi)) : y_exact_d;
        err_d      = y_exact_d - y_approx_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_exact_q   <= '0;
            y_approx_q  <= '0;
            err_q       <= '0;
        end else if (en) begin
            out_valid_q <= v1_q;
            y_exact_q   <= y_exact_d;
            y_approx_q  <= y_approx_d;
            err_q       <= err_d;
        end
    end

    // Statistics: clear beats a coincident handshake; every counter saturates.
    always_comb begin
        n_samples_d = n_samples_q;
        n_err_d     = n_err_q;
        sum_err_d   = sum_err_q;
        max_err_d   = max_err_q;
        sum_wide    = SW'(sum_err_q) + SW'(err_q);
        if (stat_clr) begin
            n_samples_d = '0;
            n_err_d     = '0;
            sum_err_d   = '0;
            max_err_d   = '0;
        end else if (out_hs) begin
            if (n_samples_q != CNT_ALL) n_samples_d = n_samples_q + CNT_W'(1);
            if ((err_q != '0) && (n_err_q != CNT_ALL)) n_err_d = n_err_q + CNT_W'(1);
            sum_err_d = (sum_wide > SW'(CNT_ALL)) ? CNT_ALL : sum_wide[CNT_W-1:0];
            if (err_q > max_err_q) max_err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_samples_q <= '0;
            n_err_q     <= '0;
            sum_err_q   <= '0;
            max_err_q   <= '0;
        end else begin
            n_samples_q <= n_samples_d;
            n_err_q     <= n_err_d;
            sum_err_q   <= sum_err_d;
            max_err_q   <= max_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y_exact   = y_exact_q;
    assign y_approx  = y_approx_q;
    assign err_dist  = err_q;
    assign n_samples = n_samples_q;
    assign n_err     = n_err_q;
    assign sum_err   = sum_err_q;
    assign max_err   = max_err_q;

endmodule

// File: tb/tb_madd_approx_pipe_eval.sv
// Scoreboard bench for madd_approx_pipe_eval: driver pushes model results, a negedge
// monitor pops them on output handshakes and tracks the expected statistics.
module tb_madd_approx_pipe_eval;

    localparam int W     = 6;
    localparam int PW    = 2 * W;
    localparam int TRUNC = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid, approx_en, stat_clr;
    logic [W-1:0]  a, b, c;
    logic          out_ready = 1'b1;

    logic          in_ready, out_valid;
    logic [PW-1:0] y_exact, y_approx, err_dist, max_err;
    logic [31:0]   n_samples, n_err, sum_err;

    logic          s_in_ready, s_out_valid;
    logic [PW-1:0] s_y_exact, s_y_approx, s_err_dist, s_max_err;
    logic [3:0]    s_n_samples, s_n_err, s_sum_err;

    logic          z_in_ready, z_out_valid;
    logic [PW-1:0] z_y_exact, z_y_approx, z_err_dist, z_max_err;
    logic [31:0]   z_n_samples, z_n_err, z_sum_err;

    madd_approx_pipe_eval #(.W(W), .TRUNC(TRUNC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_exact(y_exact), .y_approx(y_approx), .err_dist(err_dist),
        .stat_clr(stat_clr), .n_samples(n_samples), .n_err(n_err),
        .sum_err(sum_err), .max_err(max_err));

    madd_approx_pipe_eval #(.W(W), .TRUNC(TRUNC), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .c(c), .approx_en(approx_en),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .y_exact(s_y_exact), .y_approx(s_y_approx), .err_dist(s_err_dist),
        .stat_clr(stat_clr), .n_samples(s_n_samples), .n_err(s_n_err),
        .sum_err(s_sum_err), .max_err(s_max_err));

    madd_approx_pipe_eval #(.W(W), .TRUNC(0), .CNT_W(32)) dut_t0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
        .a(a), .b(b), .c(c), .approx_en(approx_en),
        .out_valid(z_out_valid), .out_ready(out_ready),
        .y_exact(z_y_exact), .y_approx(z_y_approx), .err_dist(z_err_dist),
        .stat_clr(stat_clr), .n_samples(z_n_samples), .n_err(z_n_err),
        .sum_err(z_sum_err), .max_err(z_max_err));

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [3*PW-1:0] exp_q[$];
    longint m_n = 0, m_err = 0, m_sum = 0, m_max = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: exact = a*b+c; dropped = low TRUNC bits of c plus all a_i*b_j*2^(i+j) with i+j<TRUNC.
    function automatic logic [3*PW-1:0] model(input int av, input int bv, input int cv, input bit en);
        int exact, dropped;
        exact   = av * bv + cv;
        dropped = cv % (1 << TRUNC);
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (i + j < TRUNC) dropped += ((av >> i) & 1) * ((bv >> j) & 1) * (1 << (i + j));
        if (!en) dropped = 0;
        return {PW'(exact), PW'(exact - dropped), PW'(dropped)};
    endfunction

    function automatic longint sat(input longint v, input int cw);
        longint lim;
        lim = (longint'(1) << cw) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // ---------------- out_ready generator ----------------
    // mode 0: always ready, 1: random, 2: stall 3 cycles from first out_valid, 3: never ready
    int rdy_mode  = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (out_valid && stall_cnt < 3) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else out_ready = 1'b1;
            end
            default: out_ready = 1'b0;
        endcase
        if (rdy_mode != 2) stall_cnt = 0;
    end

    // ---------------- monitor / scoreboard ----------------
    logic            held_valid = 1'b0;
    logic [3*PW-1:0] held;
    always @(negedge clk) begin
        logic [3*PW-1:0] e;
        if (!rst) begin
            if (out_valid && !out_ready) chk("in_ready_low_when_stalled", in_ready, 0);
            if (held_valid && out_valid) chk("output_stable_in_stall", {y_exact, y_approx, err_dist}, held);
            held_valid = out_valid && !out_ready;
            held       = {y_exact, y_approx, err_dist};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got y_exact=%0d, expected no output", y_exact);
                end else begin
                    e = exp_q.pop_front();
                    chk("y_exact",  y_exact,  e[3*PW-1:2*PW]);
                    chk("y_approx", y_approx, e[2*PW-1:PW]);
                    chk("err_dist", err_dist, e[PW-1:0]);
                    chk("t0_y_approx", z_y_approx, e[3*PW-1:2*PW]);
                    chk("t0_err_dist", z_err_dist, 0);
                    if (!stat_clr) begin
                        m_n++;
                        if (e[PW-1:0] != 0) m_err++;
                        m_sum += longint'(e[PW-1:0]);
                        if (longint'(e[PW-1:0]) > m_max) m_max = longint'(e[PW-1:0]);
                    end
                end
            end
            if (stat_clr) begin
                m_n = 0; m_err = 0; m_sum = 0; m_max = 0;
            end
        end
    end

    // ---------------- driver tasks (all start and end at posedge+1) ----------------
    task automatic send(input int av, input int bv, input int cv, input bit en);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        in_valid  = 1'b1;
        a         = W'(av);
        b         = W'(bv);
        c         = W'(cv);
        approx_en = en;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                exp_q.push_back(model(av, bv, cv, en));
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL input_accept_timeout: got in_ready=0 for %0d cycles, expected accept", n);
        end
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s_drain: got %0d results outstanding, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        chk({tag, "_n_samples"}, n_samples, sat(m_n, 32));
        chk({tag, "_n_err"},     n_err,     sat(m_err, 32));
        chk({tag, "_sum_err"},   sum_err,   sat(m_sum, 32));
        chk({tag, "_max_err"},   max_err,   m_max);
        chk({tag, "_s_n_samples"}, s_n_samples, sat(m_n, 4));
        chk({tag, "_s_n_err"},     s_n_err,     sat(m_err, 4));
        chk({tag, "_s_sum_err"},   s_sum_err,   sat(m_sum, 4));
        chk({tag, "_s_max_err"},   s_max_err,   m_max);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        in_valid = 1'b0; approx_en = 1'b0; stat_clr = 1'b0;
        a = '0; b = '0; c = '0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_y_exact", y_exact, 0);
        chk("reset_n_samples", n_samples, 0);
        chk("reset_max_err", max_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("in_ready_after_reset", in_ready, 1);

        // 1: all-ones operands, exact 2-cycle latency
        send(63, 63, 63, 1);
        chk("latency_not_early", out_valid, 0);
        @(posedge clk);
        #1 chk("latency_two_cycles", out_valid, 1);
        check_stats("t1");

        // 2: two directed samples with fresh statistics
        clear_stats();
        send(5, 1, 2, 1);
        send(8, 8, 8, 1);
        check_stats("t2");
        chk("t2_spec_n_samples", n_samples, 2);
        chk("t2_spec_sum_err", sum_err, 7);

        // 3: four back-to-back samples with a 3-cycle output stall
        clear_stats();
        rdy_mode = 2;
        send(63, 63, 63, 1);
        send(5, 1, 2, 1);
        send(8, 8, 8, 1);
        send(7, 9, 5, 1);
        check_stats("t3");
        chk("t3_stall_seen", stall_cnt, 3);
        rdy_mode = 0;

        // 4: saturation of the 4-bit counters
        clear_stats();
        for (int i = 0; i < 20; i++) send(63, 63, 63, 1);
        check_stats("t4");
        chk("t4_spec_s_sum_err", s_sum_err, 15);
        chk("t4_spec_s_max_err", s_max_err, 24);

        // 5: stat_clr coinciding with an output handshake
        send(10, 20, 30, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_out_valid_seen", out_valid, 1);
        clear_stats();
        check_stats("t5_clr");
        chk("t5_spec_cleared", n_samples, 0);
        send(3, 3, 3, 1);
        check_stats("t5_next");

        // 6: asynchronous reset with two samples in flight
        rdy_mode = 3;
        @(posedge clk);
        #2;
        send(33, 44, 55, 1);
        send(12, 34, 56, 1);
        @(posedge clk);
        #3;
        chk("t6_in_flight", out_valid, 1);
        rst = 1'b1;
        exp_q.delete();
        m_n = 0; m_err = 0; m_sum = 0; m_max = 0;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_n_samples", n_samples, 0);
        chk("t6_rst_sum_err", sum_err, 0);
        chk("t6_rst_max_err", max_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1 chk("t6_in_ready", in_ready, 1);
        send(1, 1, 0, 0);
        check_stats("t6");

        // random traffic with random back-pressure, gaps and approx_en
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            int av, bv, cv;
            av = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 63));
            bv = ($urandom_range(0, 7) == 0) ? 0  : int'($urandom_range(0, 63));
            cv = int'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
            send(av, bv, cv, $urandom_range(0, 3) != 0);
        end
        rdy_mode = 0;
        check_stats("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion by 500000, expected finish");
        $fatal(1);
    end

endmodule
